sba_mem_arbiter: RTL
====================

// Module: sba_mem_arbiter
// PURPOSE
//  Shares the single dmem port between the rv32 pipeline (M stage) and debug-module system-bus access (SBA).
//  Sits between riscv/dm and dmem in top. One debug transaction is in flight at a time.
//  The CPU has priority unless halted (DebugMode) or starved out by the optional stall mechanism.
// PARAMETERS
//  ADDR_WIDTH    32  address width, byte address
//  DATA_WIDTH    32  data width, word only
//  STARVE_LIMIT  16  denied ARB cycles before CpuStall is forced (SBA_STALL_EN only); must be >= 1
// PORTS
//  sysclk       in   1   clock; all state updates on the rising edge
//  sys_reset    in   1   asynchronous, active-low reset
//  DataAdrM     in   32  CPU address
//  WriteDataM   in   32  CPU store data
//  MemWriteM    in   1   CPU store strobe
//  CpuMemReqM   in   1   CPU load or store in M this cycle
//  DebugMode    in   1   hart halted
//  ReadDataM    out  32  CPU load data (= MemRData)
//  CpuStall     out  1   hold CPU M stage this cycle
//  SbReqValid   in   1   debug request valid
//  SbReqReady   out  1   request accepted when valid&ready
//  SbWrite      in   1   1=write, 0=read
//  SbAddr       in   32  request address
//  SbWData      in   32  request write data
//  SbRspValid   out  1   response valid, held until ready
//  SbRspReady   in   1   response consumed when valid&ready
//  SbRData      out  32  read data (0 for writes)
//  SbErr        out  1   misaligned-address error
//  MemWe        out  1   to dmem
//  MemAdr       out  32  to dmem
//  MemWData     out  32  to dmem
//  MemRData     in   32  from dmem, combinational read
// BEHAVIOUR
//  - Reset values: state IDLE, SbRspValid/SbErr/CpuStall=0, SbRData=0, StarveCnt=0; captured request regs cleared.
//  - FSM states IDLE, ARB, RESP.
//  - SbReqReady = (state==IDLE).
//  - IDLE: on valid&ready, capture {SbWrite,SbAddr,SbWData}.
//    - If SbAddr[1:0]!=0: go to RESP with SbErr=1 and SbRData=0. No memory access occurs.
//    - Otherwise go to ARB.
//  - ARB: Grant = DebugMode | ~CpuMemReqM | ForceStall.
//    - On Grant, the debug access occurs this cycle: MemAdr/MemWData/MemWe come from the captured request, and the CPU store is suppressed.
//    - A read captures MemRData into SbRData at the clock edge. Then go to RESP with SbErr=0.
//    - If not granted: StarveCnt++ (saturating). StarveCnt is cleared on leaving ARB.
//  - Outside a granted ARB cycle the mux passes the CPU signals: MemWe=MemWriteM, MemAdr=DataAdrM, MemWData=WriteDataM.
//  - ReadDataM = MemRData always.
//  - RESP: SbRspValid=1. SbRData/SbErr stay stable until SbRspReady, then go to IDLE. Back-to-back requests are accepted only from IDLE.
//  - Latency: accept at N, access at N+1 if the port is free, SbRspValid at N+2. Misaligned request: SbRspValid at N+1.
//  - MemWe is asserted for exactly one cycle per debug write.
//  - DebugMode changing mid-ARB takes effect in the same cycle (Grant is combinational).
//  - Reset mid-operation aborts the transaction.
//    - A write already performed in a granted ARB cycle stays committed.
//    - No response is issued for the aborted request.
// CONFIGURATION
//  SBA_STALL_EN defined:
//    - ForceStall = (state==ARB) & (StarveCnt==STARVE_LIMIT).
//    - CpuStall = ForceStall (combinational, one cycle). The access happens in that cycle.
//  SBA_STALL_EN undefined:
//    - CpuStall tied 0, ForceStall=0, no counter.
//    - A debug request waits indefinitely while the CPU is busy and not halted.
// STRUCTURE
//  - sba_req_t/sba_rsp_t typedefs and the sba_state_t enum go in the shared debug.vh package, alongside dmi_req_t/dmi_rsp_t.
//  - No sub-module: a single FSM plus the mux and counter.
//  - top instantiates it between riscv, dm and dmem.
// TESTING
//  1. DebugMode=1, dmem[0x40]=0xDEADBEEF, read 0x40 accepted at cycle 0
//     -> SbRspValid at cycle 2, SbRData=0xDEADBEEF, SbErr=0.
//  2. CpuMemReqM=0, write 0x80 <- 0x12345678
//     -> MemWe high exactly 1 cycle with MemAdr=0x80; a following read of 0x80 returns 0x12345678.
//  3. Read 0x42
//     -> SbRspValid next cycle, SbErr=1, SbRData=0, MemWe never asserted from the debug side.
//  4. CpuMemReqM=1 constant, DebugMode=0, STARVE_LIMIT=4:
//     - SBA_STALL_EN defined -> access in the 5th ARB cycle, CpuStall high exactly that cycle.
//     - SBA_STALL_EN undefined -> no access until CpuMemReqM drops; access occurs the same cycle it drops.
//  5. SbRspReady held low 10 cycles after a read
//     -> SbRspValid stays 1, SbRData stable, SbReqReady=0 throughout.
//  6. sys_reset pulsed low during ARB with a pending write
//     -> all outputs reach reset values asynchronously; no MemWe from the debug side; SbReqReady=1 after release.

Source files
------------

// File: rtl/sba_mem_arbiter_pkg.sv
// Shared types for the dmem arbiter that sits between the rv32 M stage and debug system-bus access.
package sba_mem_arbiter_pkg;

  localparam int unsigned SBA_ADDR_W       = 32;
  localparam int unsigned SBA_DATA_W       = 32;
  localparam int unsigned SBA_STARVE_LIMIT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    RESP = 2'd2
  } sba_state_t;

  typedef struct packed {
    logic                  write;
    logic [SBA_ADDR_W-1:0] addr;
    logic [SBA_DATA_W-1:0] wdata;
  } sba_req_t;

  typedef struct packed {
    logic                  err;
    logic [SBA_DATA_W-1:0] rdata;
  } sba_rsp_t;

  // Only word accesses are supported.
  function automatic logic isMisaligned(input logic [SBA_ADDR_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/sba_mem_arbiter_if.sv
// System-bus access request/response channel between the debug module (master) and the arbiter (slave).
interface sba_mem_arbiter_if;
  import sba_mem_arbiter_pkg::*;

  logic                  SbReqValid;
  logic                  SbReqReady;
  logic                  SbWrite;
  logic [SBA_ADDR_W-1:0] SbAddr;
  logic [SBA_DATA_W-1:0] SbWData;
  logic                  SbRspValid;
  logic                  SbRspReady;
  logic [SBA_DATA_W-1:0] SbRData;
  logic                  SbErr;

  modport master (
    output SbReqValid, SbWrite, SbAddr, SbWData, SbRspReady,
    input  SbReqReady, SbRspValid, SbRData, SbErr
  );

  modport slave (
    input  SbReqValid, SbWrite, SbAddr, SbWData, SbRspReady,
    output SbReqReady, SbRspValid, SbRData, SbErr
  );

endinterface

// File: rtl/sba_mem_arbiter.sv
// Shares the single dmem port between the CPU M stage and one in-flight debug SBA transaction.
// Optional starvation breaker: define SBA_STALL_EN to force a CPU stall after STARVE_LIMIT denied cycles.
module sba_mem_arbiter
  import sba_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = SBA_ADDR_W,
  parameter int unsigned DATA_WIDTH   = SBA_DATA_W,
  parameter int unsigned STARVE_LIMIT = SBA_STARVE_LIMIT
) (
  input  logic                  sysclk,
  input  logic                  sys_reset,
  input  logic [ADDR_WIDTH-1:0] DataAdrM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic                  MemWriteM,
  input  logic                  CpuMemReqM,
  input  logic                  DebugMode,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  CpuStall,
  sba_mem_arbiter_if.slave      sb,
  output logic                  MemWe,
  output logic [ADDR_WIDTH-1:0] MemAdr,
  output logic [DATA_WIDTH-1:0] MemWData,
  input  logic [DATA_WIDTH-1:0] MemRData
);

  sba_state_t state, stateNext;
  sba_req_t   reqQ, reqNext;
  sba_rsp_t   rspQ, rspNext;
  logic       forceStall;
  logic       grant;
  logic       debugAccess;

  assign grant = DebugMode | ~CpuMemReqM | forceStall;

`ifdef SBA_STALL_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starveCnt;

  assign forceStall = (state == ARB) && (starveCnt == CNT_W'(STARVE_LIMIT));
  assign CpuStall   = forceStall;

  // Counts denied ARB cycles; cleared when the access is finally granted.
  always_ff @(posedge sysclk or negedge sys_reset) begin
    if (!sys_reset) begin
      starveCnt <= '0;
    end else if (state == ARB) begin
      if (grant) begin
        starveCnt <= '0;
      end else if (starveCnt != CNT_W'(STARVE_LIMIT)) begin
        starveCnt <= starveCnt + CNT_W'(1);
      end
    end
  end
`else
  logic unusedStarveLimit;

  assign unusedStarveLimit = ^STARVE_LIMIT;
  assign forceStall        = 1'b0;
  assign CpuStall          = 1'b0;
`endif

  // State and captured request/response registers.
  always_ff @(posedge sysclk or negedge sys_reset) begin
    if (!sys_reset) begin
      state <= IDLE;
      reqQ  <= '0;
      rspQ  <= '0;
    end else begin
      state <= stateNext;
      reqQ  <= reqNext;
      rspQ  <= rspNext;
    end
  end

  always_comb begin
    stateNext   = state;
    reqNext     = reqQ;
    rspNext     = rspQ;
    debugAccess = 1'b0;
    unique case (state)
      IDLE: begin
        if (sb.SbReqValid) begin
          reqNext.write = sb.SbWrite;
          reqNext.addr  = sb.SbAddr;
          reqNext.wdata = sb.SbWData;
          // Misaligned requests are answered with an error and never reach dmem.
          if (isMisaligned(sb.SbAddr)) begin
            rspNext.err   = 1'b1;
            rspNext.rdata = '0;
            stateNext     = RESP;
          end else begin
            stateNext = ARB;
          end
        end
      end
      ARB: begin
        if (grant) begin
          debugAccess   = 1'b1;
          rspNext.err   = 1'b0;
          rspNext.rdata = reqQ.write ? '0 : SBA_DATA_W'(MemRData);
          stateNext     = RESP;
        end
      end
      RESP: begin
        if (sb.SbRspReady) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // dmem port mux: the granted debug access replaces (and suppresses) the CPU access.
  assign MemWe    = debugAccess ? reqQ.write : MemWriteM;
  assign MemAdr   = debugAccess ? ADDR_WIDTH'(reqQ.addr) : DataAdrM;
  assign MemWData = debugAccess ? DATA_WIDTH'(reqQ.wdata) : WriteDataM;

  assign ReadDataM = MemRData;

  assign sb.SbReqReady = (state == IDLE);
  assign sb.SbRspValid = (state == RESP);
  assign sb.SbRData    = rspQ.rdata;
  assign sb.SbErr      = rspQ.err;

endmodule
